// File: rtl/pc_fetch_ctrl_if.sv
// Bundles the fetch controller's table, init-ROM, branch and PC signals.
// master = fetch controller, slave = surrounding pipeline/table/ROM.
interface pc_fetch_ctrl_if #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned IDX_W = 5
);
   logic             start;
   logic [PC_W-1:0]  init_data;
   logic [IDX_W-1:0] init_addr;
   logic [IDX_W-1:0] blut_index;
   logic [PC_W-1:0]  blut_wdata;
   logic             blut_we;
   logic [PC_W-1:0]  blut_target;
   logic             branch_req;
   logic             branch_taken;
   logic [IDX_W-1:0] branch_index;
   logic             halt_req;
   logic [PC_W-1:0]  pc;
   logic             pc_valid;
   logic             stall;
   logic             done;

   modport master (
      input  start, init_data, blut_target, branch_req, branch_taken, branch_index, halt_req,
      output init_addr, blut_index, blut_wdata, blut_we, pc, pc_valid, stall, done
   );

   modport slave (
      output start, init_data, blut_target, branch_req, branch_taken, branch_index, halt_req,
      input  init_addr, blut_index, blut_wdata, blut_we, pc, pc_valid, stall, done
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC / fetch sequencer: loads the branch lookup table from the init ROM,
// then steps the PC and redirects through the table on taken branches.
module pc_fetch_ctrl #(
   parameter int unsigned    PC_W        = 10,
   parameter int unsigned    IDX_W       = 5,
   parameter int unsigned    NUM_ENTRIES = 32,
   parameter logic [PC_W-1:0] RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               reset,
   pc_fetch_ctrl_if.master    bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_BR_WAIT,
      S_HALT
   } state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             we_q, we_d;
   logic             valid_q, valid_d;
   logic             stall_q, stall_d;
   logic             done_q, done_d;
   logic             br_take_c;
   logic [IDX_W-1:0] blut_index_c;

   // Next-state, next-PC and next registered-output decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      br_take_c = (state_q == S_RUN) && !bus.halt_req && bus.branch_req && bus.branch_taken;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
         S_INIT: begin
            if (cnt_q == LAST_IDX) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         S_RUN: begin
            if (bus.halt_req) begin
               state_d = S_HALT;
            end else if (br_take_c) begin
               state_d = S_BR_WAIT;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         S_BR_WAIT: begin
            pc_d    = bus.blut_target;
            state_d = S_RUN;
         end
         S_HALT: begin
            if (bus.start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Table index is presented in the issuing cycle; otherwise it holds its last value
      if (state_q == S_INIT) begin
         blut_index_c = cnt_q;
      end else if (br_take_c) begin
         blut_index_c = bus.branch_index;
      end else begin
         blut_index_c = idx_q;
      end
      idx_d = blut_index_c;

      we_d    = (state_d == S_INIT);
      valid_d = (state_d == S_RUN);
      stall_d = (state_d == S_INIT) || (state_d == S_BR_WAIT);
      done_d  = (state_d == S_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
         stall_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
         done_q  <= done_d;
      end
   end

   assign bus.init_addr  = cnt_q;
   assign bus.blut_index = blut_index_c;
   assign bus.blut_wdata = we_q ? bus.init_data : '0;
   assign bus.blut_we    = we_q;
   assign bus.pc         = pc_q;
   assign bus.pc_valid   = valid_q;
   assign bus.stall      = stall_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a rule-level model checked every cycle,
// plus hand-computed expectations at the interesting points.
module tb_pc_fetch_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   we_cnt = 0;

   pc_fetch_ctrl_if #(.PC_W(10), .IDX_W(5)) bus ();

   pc_fetch_ctrl #(.PC_W(10), .IDX_W(5), .NUM_ENTRIES(32), .RESET_PC(10'h000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Init ROM: entry a holds 0x100 + a
   assign bus.init_data = 10'h100 + 10'(bus.init_addr);

   // Branch lookup table with registered read
   logic [9:0] ram [32];
   initial for (int i = 0; i < 32; i++) ram[i] = 10'h000;
   initial bus.blut_target = 10'h000;
   always @(posedge clk) begin
      if (bus.blut_we) ram[bus.blut_index] <= bus.blut_wdata;
      else             bus.blut_target <= ram[bus.blut_index];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, PC, init progress, last table index, expected table
   localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_BRW = 3, M_HALT = 4;
   int         m_mode = M_IDLE;
   logic [9:0] m_pc   = 10'h000;
   int         m_cnt  = 0;
   logic [4:0] m_idx  = 5'd0;
   logic [9:0] m_tbl [32];

   function automatic logic [4:0] exp_index();
      if (m_mode == M_INIT) return 5'(m_cnt);
      if (m_mode == M_RUN && !bus.halt_req && bus.branch_req && bus.branch_taken)
         return bus.branch_index;
      return m_idx;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = M_IDLE;
         m_pc   = 10'h000;
         m_cnt  = 0;
         m_idx  = 5'd0;
      end else begin
         m_idx = exp_index();
         case (m_mode)
            M_IDLE: if (bus.start) begin m_mode = M_INIT; m_cnt = 0; end
            M_INIT: begin
               m_tbl[m_cnt] = 10'h100 + 10'(m_cnt);
               if (m_cnt == 31) begin m_mode = M_RUN; m_pc = 10'h000; end
               else m_cnt = m_cnt + 1;
            end
            M_RUN: begin
               if (bus.halt_req) m_mode = M_HALT;
               else if (bus.branch_req && bus.branch_taken) m_mode = M_BRW;
               else m_pc = 10'((int'(m_pc) + 1) % 1024);
            end
            M_BRW: begin m_pc = m_tbl[m_idx]; m_mode = M_RUN; end
            M_HALT: if (bus.start) begin m_mode = M_RUN; m_pc = 10'h000; end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (bus.blut_we) we_cnt++;
      chk("pc", 32'(bus.pc), 32'(m_pc));
      chk("pc_valid", 32'(bus.pc_valid), 32'(m_mode == M_RUN));
      chk("stall", 32'(bus.stall), 32'(m_mode == M_INIT || m_mode == M_BRW));
      chk("done", 32'(bus.done), 32'(m_mode == M_HALT));
      chk("blut_we", 32'(bus.blut_we), 32'(m_mode == M_INIT));
      chk("blut_index", 32'(bus.blut_index), 32'(exp_index()));
      if (m_mode == M_INIT) begin
         chk("init_addr", 32'(bus.init_addr), 32'(m_cnt));
         chk("blut_wdata", 32'(bus.blut_wdata), 32'(10'h100 + 10'(m_cnt)));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_br();
      bus.branch_req   = 1'b0;
      bus.branch_taken = 1'b0;
      bus.halt_req     = 1'b0;
      bus.branch_index = 5'd0;
   endtask

   initial begin
      bus.start = 1'b0;
      clr_br();
      #1 reset = 1'b1;
      #1;
      chk("rst_pc", 32'(bus.pc), 32'h000);
      chk("rst_outs", {28'd0, bus.pc_valid, bus.stall, bus.done, bus.blut_we}, 32'h0);
      repeat (2) step();
      reset = 1'b0;
      step();

      // Full init then RUN from pc 0
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (32) step();
      chk("init_we_count", 32'(we_cnt), 32'd32);
      chk("run_pc0", 32'(bus.pc), 32'h000);
      chk("run_valid", 32'(bus.pc_valid), 32'h1);

      repeat (5) step();
      chk("seq_pc5", 32'(bus.pc), 32'h005);
      repeat (2) step();
      chk("seq_pc7", 32'(bus.pc), 32'h007);

      // Taken branch through entry 3
      bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_index = 5'd3;
      #1 chk("br_index", 32'(bus.blut_index), 32'd3);
      step(); clr_br();
      chk("brw_stall", 32'(bus.stall), 32'h1);
      chk("brw_valid", 32'(bus.pc_valid), 32'h0);
      chk("brw_index", 32'(bus.blut_index), 32'd3);
      step();
      chk("br_target", 32'(bus.pc), 32'h103);
      chk("br_valid", 32'(bus.pc_valid), 32'h1);

      // Not-taken branch is sequential
      bus.branch_req = 1'b1; bus.branch_taken = 1'b0; bus.branch_index = 5'd7;
      step(); clr_br();
      chk("nt_pc", 32'(bus.pc), 32'h104);
      chk("nt_stall", 32'(bus.stall), 32'h0);

      // Halt wins over a simultaneous taken branch
      bus.halt_req = 1'b1; bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_index = 5'd5;
      step(); clr_br();
      chk("halt_done", 32'(bus.done), 32'h1);
      chk("halt_pc", 32'(bus.pc), 32'h104);
      chk("halt_valid", 32'(bus.pc_valid), 32'h0);
      bus.halt_req = 1'b1; bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_index = 5'd9;
      repeat (2) step(); clr_br();
      chk("halt_hold_pc", 32'(bus.pc), 32'h104);

      // Restart from HALT: no table reload
      bus.start = 1'b1; step(); bus.start = 1'b0;
      chk("restart_pc", 32'(bus.pc), 32'h000);
      chk("restart_done", 32'(bus.done), 32'h0);
      chk("restart_no_we", 32'(we_cnt), 32'd32);

      // PC wrap
      repeat (1023) step();
      chk("pc_max", 32'(bus.pc), 32'h3FF);
      step();
      chk("pc_wrap", 32'(bus.pc), 32'h000);

      // Last table entry
      bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_index = 5'd31;
      step(); clr_br(); step();
      chk("br_last", 32'(bus.pc), 32'h11F);

      // Return to IDLE, start a new init and abort it at counter 12
      reset = 1'b1; step(); reset = 1'b0;
      we_cnt = 0;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (12) step();
      chk("mid_init_addr", 32'(bus.init_addr), 32'd12);
      #1 reset = 1'b1;
      #1;
      chk("abort_writes", 32'(we_cnt), 32'd12);
      chk("abort_pc", 32'(bus.pc), 32'h000);
      chk("abort_outs", {28'd0, bus.pc_valid, bus.stall, bus.done, bus.blut_we}, 32'h0);
      chk("abort_addr", 32'(bus.init_addr), 32'd0);
      step();
      reset = 1'b0;
      we_cnt = 0;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (32) step();
      chk("reinit_we_count", 32'(we_cnt), 32'd32);
      chk("reinit_pc", 32'(bus.pc), 32'h000);
      chk("reinit_valid", 32'(bus.pc_valid), 32'h1);

      bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_index = 5'd12;
      step(); clr_br(); step();
      chk("reinit_br", 32'(bus.pc), 32'h10C);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
